// File: rtl/fhe_alu_pkg.sv
// Shared FHE ALU types and constants used by the twiddle return path.
// Built with or without ROOT_RET_CHECK_EN (see root_return_router).
package FHE_ALU_PKG;
  localparam int FSIZE          = 16;
  localparam int E              = 4;
  localparam int logE           = 2;
  localparam int NTT_INTT_NUM   = 4;
  localparam int ROOT_POWER_NUM = 4;
  localparam int ROOT_ADDR_LAT  = 3;
  localparam int ROOT_RAM_LAT   = 2;

  typedef logic [logE-1:0][E/2-1:0][FSIZE-1:0] root_beat_t;

  // select width, never zero even for a single target
  function automatic int sel_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/root_sel_delay.sv
// Fixed-depth shift register with synchronous clear.
// Carries request valids and selects alongside the RAM read.
module root_sel_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [DEPTH-1:0][W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/root_return_router.sv
// Routes root-power RAM read data back to the requesting NTT units.
// Define ROOT_RET_CHECK_EN to enable the sticky routing-mismatch check.
module root_return_router
  import FHE_ALU_PKG::*;
#(
  parameter int NTT_INTT_NUM_IN_ROOT   = NTT_INTT_NUM,
  parameter int ROOT_POWER_NUM_IN_ROOT = ROOT_POWER_NUM,
  parameter int ADDR_LAT               = ROOT_ADDR_LAT,
  parameter int RAM_LAT                = ROOT_RAM_LAT,
  parameter int CNT_W                  = 8,
  localparam int NN  = NTT_INTT_NUM_IN_ROOT,
  localparam int NR  = ROOT_POWER_NUM_IN_ROOT,
  localparam int RSW = sel_w(NR),
  localparam int NSW = sel_w(NN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NN-1:0]                  req_vld,
  input  logic [NN-1:0][RSW-1:0]         root_select,
  input  logic [NR-1:0][NSW-1:0]         ntt_intt_select,
  input  root_beat_t [NR-1:0]            root_output_W,
  input  root_beat_t [NR-1:0]            root_output_WQ,
  output root_beat_t [NN-1:0]            ntt_input_W,
  output root_beat_t [NN-1:0]            ntt_input_WQ,
  output logic [NN-1:0]                  ntt_input_vld,
  output logic [NN-1:0][CNT_W-1:0]       beat_cnt,
  output logic [NN-1:0]                  err_ntt
);
  localparam int D = ADDR_LAT + RAM_LAT;

  logic [NN-1:0]          dly_vld;
  logic [NN-1:0][RSW-1:0] dly_sel;

  for (genvar n = 0; n < NN; n++) begin : g_ntt
    logic [RSW:0] dq;
    root_sel_delay #(.W(RSW + 1), .DEPTH(D)) u_dly (
      .clk (clk),
      .rst (rst),
      .d_i ({req_vld[n], root_select[n]}),
      .q_o (dq)
    );
    assign dly_vld[n] = dq[RSW];
    assign dly_sel[n] = dq[RSW-1:0];
  end

`ifdef ROOT_RET_CHECK_EN
  logic [NR-1:0][NSW-1:0] dly_nsel;
  root_sel_delay #(.W(NR * NSW), .DEPTH(D)) u_nsel (
    .clk (clk),
    .rst (rst),
    .d_i (ntt_intt_select),
    .q_o (dly_nsel)
  );
`else
  logic unused_nsel;
  assign unused_nsel = ^ntt_intt_select;
`endif

  logic [NN-1:0]             vld_q, vld_d;
  root_beat_t [NN-1:0]       w_q, w_d;
  root_beat_t [NN-1:0]       wq_q, wq_d;
  logic [NN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NN-1:0]             err_q, err_d;

  always_comb begin
    vld_d = dly_vld;
    w_d   = w_q;
    wq_d  = wq_q;
    cnt_d = cnt_q;
    err_d = err_q;
    for (int n = 0; n < NN; n++) begin
      if (dly_vld[n]) begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
        // out-of-range bank still counts as a beat, with zero data
        if (int'(dly_sel[n]) < NR) begin
          w_d[n]  = root_output_W[dly_sel[n]];
          wq_d[n] = root_output_WQ[dly_sel[n]];
        end else begin
          w_d[n]  = '0;
          wq_d[n] = '0;
        end
`ifdef ROOT_RET_CHECK_EN
        if (int'(dly_sel[n]) < NR) begin
          if (int'(dly_nsel[dly_sel[n]]) != n) begin
            err_d[n] = 1'b1;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      w_q   <= '0;
      wq_q  <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= vld_d;
      w_q   <= w_d;
      wq_q  <= wq_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ntt_input_vld = vld_q;
  assign ntt_input_W   = w_q;
  assign ntt_input_WQ  = wq_q;
  assign beat_cnt      = cnt_q;
  assign err_ntt       = err_q;
endmodule

// File: tb/tb_root_return_router.sv
// Scoreboard bench for root_return_router.
// Honors ROOT_RET_CHECK_EN for the expected err_ntt values.
module tb_root_return_router;
  import FHE_ALU_PKG::*;

  localparam int NN  = NTT_INTT_NUM;
  localparam int NR  = ROOT_POWER_NUM;
  localparam int D   = ROOT_ADDR_LAT + ROOT_RAM_LAT;
  localparam int CW  = 8;
  localparam int RSW = sel_w(NR);
  localparam int NSW = sel_w(NN);
  localparam int BW  = $bits(root_beat_t);

  logic clk = 1'b0;
  logic rst;
  logic [NN-1:0]          req_vld;
  logic [NN-1:0][RSW-1:0] root_select;
  logic [NR-1:0][NSW-1:0] ntt_intt_select;
  root_beat_t [NR-1:0]    root_output_W;
  root_beat_t [NR-1:0]    root_output_WQ;
  root_beat_t [NN-1:0]    ntt_input_W;
  root_beat_t [NN-1:0]    ntt_input_WQ;
  logic [NN-1:0]          ntt_input_vld;
  logic [NN-1:0][CW-1:0]  beat_cnt;
  logic [NN-1:0]          err_ntt;

  root_return_router #(.CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_vld         (req_vld),
    .root_select     (root_select),
    .ntt_intt_select (ntt_intt_select),
    .root_output_W   (root_output_W),
    .root_output_WQ  (root_output_WQ),
    .ntt_input_W     (ntt_input_W),
    .ntt_input_WQ    (ntt_input_WQ),
    .ntt_input_vld   (ntt_input_vld),
    .beat_cnt        (beat_cnt),
    .err_ntt         (err_ntt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    root_beat_t    w;
    root_beat_t    wq;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t          sb[NN][$];
  logic [CW-1:0] mcnt[NN];
  logic          merr[NN];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic root_beat_t pat(int c, int r, int salt);
    logic [BW-1:0] t;
    t = '0;
    for (int i = 0; i < BW / 16; i++) begin
      t[i*16 +: 16] = 16'(c * 37 + r * 1009 + i * 5 + salt);
    end
    return root_beat_t'(t);
  endfunction

  task automatic chk(string nm, int n, logic [BW-1:0] act, logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s ntt%0d got=%h want=%h", nm, n, act, exp);
    end
  endtask

  task automatic drive_roots();
    for (int r = 0; r < NR; r++) begin
      root_output_W[r]  = pat(cyc, r, 0);
      root_output_WQ[r] = pat(cyc, r, 7777);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    req_vld = '0;
    drive_roots();
  endtask

  task automatic issue(int n, int sel);
    exp_t e;
    req_vld[n]     = 1'b1;
    root_select[n] = RSW'(sel);
    mcnt[n]        = mcnt[n] + CW'(1);
`ifdef ROOT_RET_CHECK_EN
    if (int'(ntt_intt_select[sel]) != n) merr[n] = 1'b1;
`endif
    e.w   = pat(cyc + D, sel, 0);
    e.wq  = pat(cyc + D, sel, 7777);
    e.cnt = mcnt[n];
    e.err = merr[n];
    sb[n].push_back(e);
  endtask

  task automatic flush();
    for (int n = 0; n < NN; n++) begin
      sb[n].delete();
      mcnt[n] = '0;
      merr[n] = 1'b0;
    end
  endtask

  task automatic do_reset(int ncyc);
    rst = 1'b1;
    flush();
    repeat (ncyc) tick();
    rst = 1'b0;
  endtask

  function automatic int pending();
    int s = 0;
    for (int n = 0; n < NN; n++) s += sb[n].size();
    return s;
  endfunction

  task automatic drain();
    for (int k = 0; k < 40 && pending() != 0; k++) tick();
    chk("drain_pending", 0, BW'(pending()), '0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int n = 0; n < NN; n++) begin
        if (ntt_input_vld[n] === 1'b1) begin
          if (sb[n].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_vld ntt%0d got=1 want=0", n);
          end else begin
            exp_t e;
            e = sb[n].pop_front();
            chk("data_W", n, BW'(ntt_input_W[n]), BW'(e.w));
            chk("data_WQ", n, BW'(ntt_input_WQ[n]), BW'(e.wq));
            chk("beat_cnt", n, BW'(beat_cnt[n]), BW'(e.cnt));
            chk("err_ntt", n, BW'(err_ntt[n]), BW'(e.err));
          end
        end
      end
    end
  end

  logic [NN-1:0] exp_err;
  int perm[NN] = '{3, 0, 1, 2};

  initial begin
    rst             = 1'b1;
    req_vld         = '0;
    root_select     = '0;
    ntt_intt_select = '0;
    flush();
    drive_roots();

    // reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_vld", 0, BW'(ntt_input_vld), '0);
    chk("rst_cnt", 0, BW'(beat_cnt), '0);
    chk("rst_err", 0, BW'(err_ntt), '0);
    chk("rst_W", 0, BW'(ntt_input_W), '0);
    chk("rst_WQ", 0, BW'(ntt_input_WQ), '0);
    rst = 1'b0;
    tick();

    // single beat
    ntt_intt_select[1] = NSW'(2);
    issue(2, 1);
    tick();
    drain();
    chk("single_cnt", 2, BW'(beat_cnt[2]), BW'(1));

    // permutation burst
    do_reset(2);
    for (int r = 0; r < NN; r++) ntt_intt_select[perm[r]] = NSW'(r);
    for (int b = 0; b < 8; b++) begin
      for (int n = 0; n < NN; n++) issue(n, perm[n]);
      tick();
    end
    drain();
    for (int n = 0; n < NN; n++) begin
      chk("perm_cnt", n, BW'(beat_cnt[n]), BW'(8));
    end
    chk("perm_err", 0, BW'(err_ntt), '0);

    // mismatch then clean beats
    do_reset(1);
    ntt_intt_select[3] = NSW'(1);
    issue(0, 3);
    tick();
    ntt_intt_select[3] = NSW'(0);
    for (int b = 0; b < 20; b++) begin
      issue(0, 3);
      tick();
    end
    drain();
    for (int n = 0; n < NN; n++) exp_err[n] = merr[n];
    chk("mismatch_err", 0, BW'(err_ntt), BW'(exp_err));

    // reset mid-flight
    do_reset(1);
    ntt_intt_select[0] = NSW'(0);
    issue(0, 0);
    tick();
    tick();
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_vld", 0, BW'(ntt_input_vld), '0);
      tick();
    end

    // counter wrap
    do_reset(1);
    ntt_intt_select[2] = NSW'(1);
    for (int b = 0; b < 257; b++) begin
      issue(1, 2);
      tick();
    end
    drain();
    chk("wrap_cnt", 1, BW'(beat_cnt[1]), BW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/root_return_router.md
ROOT_RETURN_ROUTER -- requirements
Module: root_return_router

Interface
REQ-001 SHALL have parameter NTT_INTT_NUM_IN_ROOT, default NTT_INTT_NUM (4): number of NTT/INTT consumers.
REQ-002 SHALL have parameter ROOT_POWER_NUM_IN_ROOT, default ROOT_POWER_NUM (4): number of root-power RAM banks.
REQ-003 SHALL have parameter ADDR_LAT, default 3: cycles from NTT read request to RAM address presentation on the forward address path.
REQ-004 SHALL have parameter RAM_LAT, default 2: RAM read latency.
REQ-005 SHALL have parameter CNT_W, default 8: width of each per-NTT beat counter.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port req_vld, input, [NTT]: NTT n issues a root read this cycle.
REQ-009 SHALL have port root_select, input, [NTT][clog2(ROOT)]: root bank targeted by NTT n.
REQ-010 SHALL have port ntt_intt_select, input, [ROOT][clog2(NTT)]: NTT that root r's address mux serves this cycle.
REQ-011 SHALL have ports root_output_W and root_output_WQ, input, [ROOT][logE][E/2][FSIZE]: RAM read data.
REQ-012 SHALL have ports ntt_input_W and ntt_input_WQ, output, [NTT][logE][E/2][FSIZE]: routed twiddle data.
REQ-013 SHALL have port ntt_input_vld, output, [NTT]: routed data valid.
REQ-014 SHALL have port beat_cnt, output, [NTT][CNT_W]: delivered-beat count per NTT.
REQ-015 SHALL have port err_ntt, output, [NTT]: sticky routing-mismatch flag per NTT.

Function
REQ-016 SHALL capture req_vld[n], root_select[n] and all ntt_intt_select[r] each cycle into a delay line of depth D = ADDR_LAT + RAM_LAT.
REQ-017 SHALL, D cycles after capture, select root_output_W/WQ[delayed root_select[n]] for NTT n.
REQ-018 SHALL register the result into ntt_input_W/WQ[n] and assert ntt_input_vld[n] exactly D+1 cycles after req_vld[n] (6 with defaults); throughput is one beat per cycle per NTT, with no bubbles.
REQ-019 SHALL hold ntt_input_W/WQ[n] at its last value and drive ntt_input_vld[n]=0 when the delayed valid is low.
REQ-020 SHALL broadcast: several NTTs selecting the same root all receive that root's data in the same cycle.
REQ-021 SHALL drive zero data for a delayed select >= ROOT_POWER_NUM_IN_ROOT, with vld still asserted.
REQ-022 SHALL increment beat_cnt[n] on each cycle ntt_input_vld[n]=1, wrapping from 2^CNT_W-1 to 0.
REQ-023 SHALL treat a delayed req_vld[n]=0 as no beat, regardless of select values.

Reset
REQ-024 SHALL, while rst=1, clear the whole delay line, ntt_input_vld, ntt_input_W/WQ, beat_cnt and err_ntt to 0.
REQ-025 SHALL drop any request in flight when rst is asserted mid-operation; no vld is produced for it after rst deasserts.

Configuration
REQ-026 SHALL, with ROOT_RET_CHECK_EN defined, set err_ntt[n] one cycle after a delayed beat where root_select[n]=r and the delayed ntt_intt_select[r]!=n, and hold it until rst.
REQ-027 SHALL, without ROOT_RET_CHECK_EN, tie err_ntt to 0 and omit the ntt_intt_select delay line, leaving the port unused.

Structure
REQ-028 SHALL take FSIZE, logE, E, NTT_INTT_NUM and ROOT_POWER_NUM from FHE_ALU_PKG.
REQ-029 SHALL add to FHE_ALU_PKG the typedef root_beat_t ([logE][E/2][FSIZE]) and the constants ROOT_ADDR_LAT and ROOT_RAM_LAT.
REQ-030 SHALL implement the delay line as one sub-module, root_sel_delay (generic width, depth D, synchronous clear), instantiated per NTT and once for the root selects.

Verification
REQ-031 SHALL cover reset: rst for 3 cycles -> all vld 0, beat_cnt 0, err_ntt 0, data 0.
REQ-032 SHALL cover a single beat: req_vld[2]=1, root_select[2]=1, ntt_intt_select[1]=2 at cycle t, root1 data 0x1234 at t+5 -> ntt_input_vld[2]=1 at t+6, data 0x1234, beat_cnt[2]=1.
REQ-033 SHALL cover a permutation burst: 8 back-to-back beats, root_select={3,0,1,2}, matching ntt_intt_select -> each NTT receives its root's pattern, beat_cnt=8 each, err_ntt=0.
REQ-034 SHALL cover a mismatch (CHECK_EN): NTT0 selects root3 while ntt_intt_select[3]=1 -> err_ntt[0]=1 at t+6, still 1 after 20 further clean beats.
REQ-035 SHALL cover reset mid-flight: req at t, rst at t+2 for 1 cycle -> no vld on any NTT through t+10.
REQ-036 SHALL cover wrap: 256 beats to NTT1 -> beat_cnt[1]=0, the 257th beat -> 1.
